// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the IF/ID pipeline stage.
package pipe_pkg;

  // Default payload width of the core.
  localparam int PIPE_XLEN = 32;

  // addi x0,x0,0; presented to decode whenever no valid beat is held.
  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  // Buffer occupancy: EMPTY, ONE (main full), TWO (main and skid full).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  // Instruction/PC pair carried from fetch to decode.
  typedef struct packed {
    logic [PIPE_XLEN-1:0] instr;
    logic [PIPE_XLEN-1:0] pc;
  } if_id_payload_t;

endpackage

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: generic valid/ready buffer with flush over payload_t.
// Optional macro IF_ID_PIPE_SKID_EN: adds a second (skid) entry and makes
// in_ready a pure register output. Without it the buffer has one entry and
// in_ready is ~out_valid | out_ready.
module pipe_skid_buffer
  import pipe_pkg::*;
#(
  parameter type payload_t = if_id_payload_t
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     in_valid,
  output logic     in_ready,
  input  payload_t in_data,
  input  logic     flush,
  output logic     out_valid,
  input  logic     out_ready,
  output payload_t out_data
);

  stage_state_t state_reg, state_next;
  payload_t     main_reg, main_next;
  logic         in_fire;
  logic         out_fire;

`ifdef IF_ID_PIPE_SKID_EN
  payload_t skid_reg, skid_next;
  logic     in_ready_reg;

  // in_ready comes straight from a flop, so upstream timing never sees out_ready or flush.
  assign in_ready = in_ready_reg;
`else
  // Single entry: accept when empty or when the held beat leaves this cycle.
  assign in_ready = ~out_valid | out_ready;
`endif

  assign out_valid = (state_reg != EMPTY);
  assign out_data  = main_reg;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // State and main entry registers; reset drops held beats immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= EMPTY;
      main_reg  <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
    end
  end

`ifdef IF_ID_PIPE_SKID_EN
  // Skid entry and registered in_ready, low exactly while both entries are full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skid_reg     <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      skid_reg     <= skid_next;
      in_ready_reg <= (state_next != TWO);
    end
  end
`endif

  // Next-state and entry loads; flush wins and leaves the entries untouched
  // so out_pc keeps showing the last beat that was at the head.
  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
`ifdef IF_ID_PIPE_SKID_EN
    skid_next  = skid_reg;
`endif
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (in_fire) begin
            state_next = ONE;
            main_next  = in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_next = in_data;
`ifdef IF_ID_PIPE_SKID_EN
          end else if (in_fire) begin
            state_next = TWO;
            skid_next  = in_data;
`endif
          end else if (out_fire) begin
            state_next = EMPTY;
          end
        end
`ifdef IF_ID_PIPE_SKID_EN
        TWO: begin
          if (out_fire) begin
            state_next = ONE;
            main_next  = skid_reg;
          end
        end
`endif
        default: state_next = EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/if_id_pipe_stage.sv
// if_id_pipe_stage: IF/ID pipeline register with valid/ready handshake,
// flush with NOP injection and optional skid buffer.
// Optional macro IF_ID_PIPE_SKID_EN selects the two-entry skid buffer with
// registered in_ready; undefined gives a single entry.
module if_id_pipe_stage
  import pipe_pkg::*;
#(
  parameter int              XLEN      = PIPE_XLEN,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(RV_NOP)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  // Same shape as if_id_payload_t, sized by this instance's XLEN.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } stage_payload_t;

  stage_payload_t in_payload;
  stage_payload_t out_payload;
  logic           buf_valid;

  assign in_payload.instr = in_instr;
  assign in_payload.pc    = in_pc;

  pipe_skid_buffer #(
    .payload_t (stage_payload_t)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_payload),
    .flush     (flush),
    .out_valid (buf_valid),
    .out_ready (out_ready),
    .out_data  (out_payload)
  );

  // Decode sees a NOP whenever nothing valid is held; the PC keeps its last value.
  assign out_valid = buf_valid;
  assign out_instr = buf_valid ? out_payload.instr : NOP_INSTR;
  assign out_pc    = out_payload.pc;

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// tb_if_id_pipe_stage: table vectors, directed corner sequences and a
// randomized run against a queue-based reference model.
`timescale 1ns/1ps
module tb_if_id_pipe_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_ID_PIPE_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_pipe_stage #(
    .XLEN      (32),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc)
  );

  typedef struct {
    logic        v;
    logic        r;
    logic        f;
    logic [31:0] pc;
    logic        e_valid;
    logic        e_ready;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } beat_t;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0], 16'h0033} ^ 32'h5A5A_0000;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk(input string tag, input logic ev, input logic er,
                     input logic [31:0] epc, input logic [31:0] ei);
    check_bit({tag, ".out_valid"}, out_valid, ev);
    check_bit({tag, ".in_ready"}, in_ready, er);
    check_word({tag, ".out_pc"}, out_pc, epc);
    check_word({tag, ".out_instr"}, out_instr, ei);
  endtask

  // Apply inputs just after the falling edge, then let combinational outputs settle.
  task automatic step(input logic v, input logic r, input logic f, input logic [31:0] pc);
    @(negedge clk);
    in_valid  = v;
    out_ready = r;
    flush     = f;
    in_pc     = pc;
    in_instr  = instr_of(pc);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[5];
    beat_t       q[$];
    logic [31:0] last_pc;
    logic        m_valid;
    logic        m_ready;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h100, 1'b0, 1'b1, 32'h0,   NOP};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h104, 1'b1, 1'b1, 32'h100, instr_of(32'h100)};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h108, 1'b1, 1'b1, 32'h104, instr_of(32'h104)};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'h108, instr_of(32'h108)};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 1'b1, 32'h108, NOP};

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset", 1'b0, 1'b1, 32'h0, NOP);

    // Streaming table
    for (int i = 0; i < 5; i++) begin
      step(vecs[i].v, vecs[i].r, vecs[i].f, vecs[i].pc);
      $display("vec %0d: in_valid=%b in_pc=%h -> out_valid=%b out_pc=%h", i, vecs[i].v, vecs[i].pc, out_valid, out_pc);
      chk($sformatf("stream%0d", i), vecs[i].e_valid, vecs[i].e_ready, vecs[i].e_pc, vecs[i].e_instr);
    end

    // Backpressure
    step(1'b1, 1'b0, 1'b0, 32'h200);
    chk("bp0", 1'b0, 1'b1, 32'h108, NOP);
    step(1'b1, 1'b0, 1'b0, 32'h204);
`ifdef IF_ID_PIPE_SKID_EN
    chk("bp1", 1'b1, 1'b1, 32'h200, instr_of(32'h200));
    step(1'b1, 1'b0, 1'b0, 32'h208);
    chk("bp2", 1'b1, 1'b0, 32'h200, instr_of(32'h200));
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("bp3", 1'b1, 1'b0, 32'h200, instr_of(32'h200));
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("bp4", 1'b1, 1'b1, 32'h204, instr_of(32'h204));
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("bp5", 1'b0, 1'b1, 32'h204, NOP);
`else
    chk("bp1", 1'b1, 1'b0, 32'h200, instr_of(32'h200));
    out_ready = 1'b1;
    #1;
    check_bit("bp1_comb.in_ready", in_ready, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("bp2", 1'b1, 1'b1, 32'h204, instr_of(32'h204));
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("bp3", 1'b0, 1'b1, 32'h204, NOP);
`endif
    $display("backpressure: 0x200 then 0x204 drained");

    // Flush with a beat offered in the same cycle
    step(1'b1, 1'b0, 1'b0, 32'h280);
    chk("fl0", 1'b0, 1'b1, 32'h204, NOP);
    step(1'b1, 1'b0, 1'b0, 32'h284);
    chk("fl1", 1'b1, SKID, 32'h280, instr_of(32'h280));
    step(1'b1, 1'b1, 1'b1, 32'h300);
    chk("fl2", 1'b1, ~SKID, 32'h280, instr_of(32'h280));
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("fl3", 1'b0, 1'b1, 32'h280, NOP);
    step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("fl4", 1'b0, 1'b1, 32'h280, NOP);
    $display("flush: pc 0x300 discarded");

    // Asynchronous reset between edges while holding one beat
    step(1'b1, 1'b0, 1'b0, 32'h3C0);
    chk("ar0", 1'b0, 1'b1, 32'h280, NOP);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("ar1", 1'b1, SKID, 32'h3C0, instr_of(32'h3C0));
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar2", 1'b0, 1'b1, 32'h0, NOP);
    @(negedge clk);
    reset_n = 1'b1;
    $display("async reset: held beat dropped");

    // Randomized run against the occupancy-queue model
    last_pc = '0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_pc     = $urandom;
      in_instr  = $urandom;
      m_valid   = (q.size() > 0);
      if (SKID)
        m_ready = (q.size() < 2);
      else
        m_ready = (q.size() == 0) || out_ready;
      #1;
      chk($sformatf("rand%0d", c), m_valid, m_ready,
          m_valid ? q[0].pc : last_pc, m_valid ? q[0].instr : NOP);
      if (m_valid && out_ready && !flush)
        $display("rand %0d: beat out pc=%h instr=%h", c, q[0].pc, q[0].instr);
      if (flush) begin
        q.delete();
      end else begin
        if (m_valid && out_ready) void'(q.pop_front());
        if (in_valid && m_ready) q.push_back('{in_instr, in_pc});
      end
      if (q.size() > 0) last_pc = q[0].pc;
    end

    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
